button_event_ctrl: RTL and testbench

//   Per-button event generator downstream of the 2-flop input synchronizer.

---
 rtl/chrono_pkg.sv | 15 +
 rtl/button_event_ctrl_if.sv | 21 ++
 rtl/btn_event_unit.sv | 123 ++++++++++++
 rtl/button_event_ctrl.sv | 41 ++++
 tb/tb_button_event_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/chrono_pkg.sv
// Shared types and helpers for the chronometer button front end.
package chrono_pkg;

  typedef enum logic [1:0] {
    StReleased = 2'd0,
    StPressed  = 2'd1,
    StRepeat   = 2'd2
  } btn_state_t;

  // Bits needed to hold values 0..max_val; never less than one.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Button levels in, filtered level and event pulses out.
interface button_event_ctrl_if #(
  parameter int unsigned N_BTN = 4
);
  logic [N_BTN-1:0] btn_i;
  logic [N_BTN-1:0] level_o;
  logic [N_BTN-1:0] press_o;
  logic [N_BTN-1:0] release_o;
  logic [N_BTN-1:0] repeat_o;
  logic [N_BTN-1:0] long_o;

  modport master (
    output btn_i,
    input  level_o, press_o, release_o, repeat_o, long_o
  );

  modport slave (
    input  btn_i,
    output level_o, press_o, release_o, repeat_o, long_o
  );
endinterface

// File: rtl/btn_event_unit.sv
// One button: stable-time filter followed by press/hold/repeat event FSM.
module btn_event_unit
  import chrono_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 500000,
  parameter int unsigned HOLD_CYC   = 50000000,
  parameter int unsigned REPEAT_CYC = 10000000,
  parameter bit          REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o,
  output logic long_o
);
  localparam int unsigned SW   = cnt_w(STABLE_CYC);
  localparam int unsigned HMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned HW   = cnt_w(HMAX);
  localparam logic [SW-1:0] StbLast  = SW'(STABLE_CYC - 1);
  localparam logic [HW-1:0] HoldLast = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] RptLast  = HW'(REPEAT_CYC - 1);

  logic [SW-1:0] stb_d, stb_q;
  logic [HW-1:0] hold_d, hold_q;
  logic          level_d, level_q;
  logic          press_d, press_q, rel_d, rel_q, rpt_d, rpt_q, long_d, long_q;
  btn_state_t    state_d, state_q;
  logic          accept, rise, fall;

  always_comb begin
    accept  = 1'b0;
    stb_d   = stb_q;
    level_d = level_q;
    if (btn_i == level_q) begin
      stb_d = '0;
    end else if (stb_q == StbLast) begin
      level_d = ~level_q;
      stb_d   = '0;
      accept  = 1'b1;
    end else begin
      stb_d = stb_q + SW'(1);
    end
  end

  assign rise = accept & level_d;
  assign fall = accept & ~level_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    long_d  = long_q;
    unique case (state_q)
      StReleased: begin
        if (rise) begin
          state_d = StPressed;
          press_d = 1'b1;
          hold_d  = '0;
        end
      end
      StPressed, StRepeat: begin
        // A release wins over any hold/repeat expiry in the same cycle.
        if (fall) begin
          state_d = StReleased;
          rel_d   = 1'b1;
          long_d  = 1'b0;
          hold_d  = '0;
        end else if (state_q == StPressed) begin
          if (hold_q == HoldLast) begin
            state_d = StRepeat;
            rpt_d   = 1'b1;
            long_d  = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end else if (REPEAT_EN) begin
          if (hold_q == RptLast) begin
            rpt_d  = 1'b1;
            hold_d = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      default: state_d = StReleased;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StReleased;
      stb_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
      long_q  <= long_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign repeat_o  = rpt_q;
  assign long_o    = long_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Array of independent button event units behind one interface.
module button_event_ctrl
  import chrono_pkg::*;
#(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned STABLE_CYC = 500000,
  parameter int unsigned HOLD_CYC   = 50000000,
  parameter int unsigned REPEAT_CYC = 10000000,
  parameter bit          REPEAT_EN  = 1'b1
) (
  input logic                clk,
  input logic                rst,
  button_event_ctrl_if.slave bus
);
  logic [N_BTN-1:0] level, press, rel, rpt, lng;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_event_unit #(
      .STABLE_CYC (STABLE_CYC),
      .HOLD_CYC   (HOLD_CYC),
      .REPEAT_CYC (REPEAT_CYC),
      .REPEAT_EN  (REPEAT_EN)
    ) u_unit (
      .clk       (clk),
      .rst       (rst),
      .btn_i     (bus.btn_i[i]),
      .level_o   (level[i]),
      .press_o   (press[i]),
      .release_o (rel[i]),
      .repeat_o  (rpt[i]),
      .long_o    (lng[i])
    );
  end

  assign bus.level_o   = level;
  assign bus.press_o   = press;
  assign bus.release_o = rel;
  assign bus.repeat_o  = rpt;
  assign bus.long_o    = lng;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench: stimulus queues expected pulse events, a monitor pops and compares.
module tb_button_event_ctrl;
  typedef struct {
    int         at;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rpt;
    logic [3:0] lng;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  qa[$];
  ev_t  qb[$];

  button_event_ctrl_if #(.N_BTN(4)) ifa ();
  button_event_ctrl_if #(.N_BTN(4)) ifb ();

  button_event_ctrl #(
    .N_BTN(4), .STABLE_CYC(4), .HOLD_CYC(10), .REPEAT_CYC(3), .REPEAT_EN(1'b1)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  button_event_ctrl #(
    .N_BTN(4), .STABLE_CYC(4), .HOLD_CYC(10), .REPEAT_CYC(3), .REPEAT_EN(1'b0)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic push(input int d, input int at, input logic [3:0] p, input logic [3:0] rl,
                      input logic [3:0] rp, input logic [3:0] lg);
    ev_t e;
    e.at = at; e.press = p; e.rel = rl; e.rpt = rp; e.lng = lg;
    if (d == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic check_evt(input int d, input logic [3:0] p, input logic [3:0] rl,
                           input logic [3:0] rp, input logic [3:0] lg);
    ev_t e;
    int  n;
    if (!(|p || |rl || |rp)) return;
    checks++;
    n = (d == 0) ? qa.size() : qb.size();
    if (n == 0) begin
      errors++;
      $display("FAIL unexpected_evt dut%0d edge=%0d: got press=%b rel=%b rpt=%b, required none",
               d, edge_n, p, rl, rp);
      return;
    end
    if (d == 0) e = qa.pop_front();
    else e = qb.pop_front();
    if (e.at != edge_n || e.press != p || e.rel != rl || e.rpt != rp || e.lng != lg) begin
      errors++;
      $display("FAIL event dut%0d: got edge=%0d press=%b rel=%b rpt=%b long=%b, required edge=%0d press=%b rel=%b rpt=%b long=%b",
               d, edge_n, p, rl, rp, lg, e.at, e.press, e.rel, e.rpt, e.lng);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_evt(0, ifa.press_o, ifa.release_o, ifa.repeat_o, ifa.long_o);
      check_evt(1, ifb.press_o, ifb.release_o, ifb.repeat_o, ifb.long_o);
    end
  end

  task automatic check_val(input string nm, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string nm);
    check_val({nm, "_a"}, {ifa.level_o, ifa.press_o, ifa.release_o, ifa.repeat_o, ifa.long_o},
              20'h0);
    check_val({nm, "_b"}, {ifb.level_o, ifb.press_o, ifb.release_o, ifb.repeat_o, ifb.long_o},
              20'h0);
  endtask

  // Clean press held for dur cycles on one DUT, expected events derived from the timing rules.
  task automatic hold_test(input int d, input logic [3:0] mask, input int dur, input bit en);
    int t = edge_n;
    if (d == 0) ifa.btn_i = ifa.btn_i | mask;
    else ifb.btn_i = ifb.btn_i | mask;
    push(d, t + 4, mask, 4'b0, 4'b0, 4'b0);
    for (int k = t + 14; k < t + dur + 4; k += 3) begin
      push(d, k, 4'b0, 4'b0, mask, mask);
      if (!en) break;
    end
    push(d, t + dur + 4, 4'b0, mask, 4'b0, 4'b0);
    wait_n(dur);
    if (d == 0) ifa.btn_i = ifa.btn_i & ~mask;
    else ifb.btn_i = ifb.btn_i & ~mask;
    wait_n(10);
  endtask

  initial begin
    int t;
    int r;
    ifa.btn_i = 4'b0;
    ifb.btn_i = 4'b0;
    wait_n(3);
    check_all_zero("reset");
    rst = 1'b0;
    wait_n(2);
    check_all_zero("post_reset");

    // Glitch shorter than the stable time
    ifa.btn_i = 4'b0001;
    wait_n(3);
    ifa.btn_i = 4'b0000;
    wait_n(10);
    check_val("glitch_level", {16'h0, ifa.level_o}, 20'h0);

    hold_test(0, 4'b0001, 20, 1'b1);
    hold_test(0, 4'b0010, 40, 1'b1);
    hold_test(1, 4'b0010, 40, 1'b0);

    // Simultaneous press, partial release, then hold on the rest
    t = edge_n;
    ifa.btn_i = 4'b1111;
    push(0, t + 4, 4'b1111, 4'b0, 4'b0, 4'b0);
    wait_n(2);
    check_val("level_before_press", {16'h0, ifa.level_o}, 20'h0);
    wait_n(3);
    check_val("level_after_press", {16'h0, ifa.level_o}, 20'hF);
    wait_n(1);
    ifa.btn_i = 4'b1011;
    push(0, t + 10, 4'b0, 4'b0100, 4'b0, 4'b0);
    push(0, t + 14, 4'b0, 4'b0, 4'b1011, 4'b1011);
    push(0, t + 17, 4'b0, 4'b0, 4'b1011, 4'b1011);
    wait_n(9);
    ifa.btn_i = 4'b0000;
    push(0, t + 19, 4'b0, 4'b1011, 4'b0, 4'b0);
    wait_n(10);

    // Reset during REPEAT with the button still held
    t = edge_n;
    ifa.btn_i = 4'b0010;
    push(0, t + 4, 4'b0010, 4'b0, 4'b0, 4'b0);
    push(0, t + 14, 4'b0, 4'b0, 4'b0010, 4'b0010);
    wait_n(16);
    check_val("long_before_rst", {16'h0, ifa.long_o}, 20'h2);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    wait_n(1);
    rst = 1'b0;
    r = edge_n;
    push(0, r + 4, 4'b0010, 4'b0, 4'b0, 4'b0);
    wait_n(6);
    ifa.btn_i = 4'b0000;
    push(0, r + 10, 4'b0, 4'b0010, 4'b0, 4'b0);
    wait_n(10);

    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL pending_a: got %0d events outstanding, required 0", qa.size());
    end
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL pending_b: got %0d events outstanding, required 0", qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
